mem_param: RTL

- Parametrised synchronous scratch RAM; the next-generation data memory of the computer datapath.
- Generic word width and depth.
- Hardware clear sequencer walks every address after reset or on request, with a Busy flag.
- Registered read with a one-cycle Rd_valid strobe.
- Out-of-range addresses are detected and flagged.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_clr_seq.sv | 48 ++++
 rtl/mem_param.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_param scratch RAM: FSM encoding, default geometry
// and the parity helper used when MEM_PARITY_EN is defined.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Callers zero-extend their word to this width; zeros do not change parity.
    localparam int PAR_MAX_W = 1024;

    // Even parity bit: XOR of all data bits.
    function automatic logic parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_clr_seq.sv
// Clear sequencer for mem_param: walks clr_ptr over every word after RESET or on
// request and holds busy high for exactly DEPTH cycles.
module mem_clr_seq
    import mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t state;

    // Sweep FSM: one word cleared per cycle, READY once the last word is written.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state   <= ST_READY;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_param.sv
// mem_param: parametrised synchronous scratch RAM with hardware clear, registered
// read and out-of-range detection.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, Par_flip / Par_err).
module mem_param
    import mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  Mem_in,
    input  logic [ADDR_W-1:0] Address,
    input  logic              WE,
    input  logic              load,
    input  logic              OE,
    input  logic              Clear,
`ifdef MEM_PARITY_EN
    input  logic              Par_flip,
    output logic              Par_err,
`endif
    output logic [WIDTH-1:0]  Mem_out,
    output logic              Rd_valid,
    output logic              Busy,
    output logic              Addr_err
);

`ifdef MEM_PARITY_EN
    localparam int STORE_W = WIDTH + 1;
`else
    localparam int STORE_W = WIDTH;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [STORE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  clr_ptr;
    logic               clr_req, wr_req, rd_req, addr_ok, wr_go;
    logic [ADDR_W-1:0]  rd_idx;
    logic [STORE_W-1:0] wr_word, rd_word;

    mem_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (clr_req),
        .busy    (Busy),
        .clr_ptr (clr_ptr)
    );

    assign addr_ok = {1'b0, Address} < DEPTH_L;
    assign wr_go   = wr_req & addr_ok;
    // Keep the array index in range even when the request is out of range.
    assign rd_idx  = addr_ok ? Address : '0;
    assign rd_word = mem[rd_idx];

`ifdef MEM_PARITY_EN
    assign wr_word = {parity(PAR_MAX_W'(Mem_in)) ^ Par_flip, Mem_in};
`else
    assign wr_word = Mem_in;
`endif

    // Request arbitration: Clear > write (WE|load) > read; nothing accepted while busy.
    always_comb begin
        clr_req = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        if (!Busy) begin
            if (Clear) begin
                clr_req = 1'b1;
            end else if (WE || load) begin
                wr_req = 1'b1;
            end else if (OE) begin
                rd_req = 1'b1;
            end
        end
    end

    // Array write port: clear sweep while busy, else accepted in-range writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (Busy) begin
                mem[clr_ptr] <= '0;
            end else if (wr_go) begin
                mem[Address] <= wr_word;
            end
        end
    end

    // Read register and one-cycle status strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Mem_out  <= '0;
            Rd_valid <= 1'b0;
            Addr_err <= 1'b0;
`ifdef MEM_PARITY_EN
            Par_err  <= 1'b0;
`endif
        end else begin
            Rd_valid <= 1'b0;
            Addr_err <= 1'b0;
`ifdef MEM_PARITY_EN
            Par_err  <= 1'b0;
`endif
            if (wr_req && !addr_ok) begin
                Addr_err <= 1'b1;
            end
            if (rd_req) begin
                Rd_valid <= 1'b1;
                if (addr_ok) begin
                    Mem_out <= rd_word[WIDTH-1:0];
`ifdef MEM_PARITY_EN
                    Par_err <= rd_word[WIDTH] != parity(PAR_MAX_W'(rd_word[WIDTH-1:0]));
`endif
                end else begin
                    Mem_out  <= '0;
                    Addr_err <= 1'b1;
                end
            end
        end
    end

endmodule
